signed_pipelined_fixed_point_subtractor: RTL and testbench

Recovers one addend from the output of the signed pipelined fixed-point adder: computes Diff = Sum − B, so feeding the adder's Sum together with its B operand returns A. The block sits downstream of the adder in the same Q-format datapath. It is a two-stage split-carry pipeline with a valid/ready handshake and full backpressure, sustaining one result per cycle.

---
 rtl/signed_pipelined_fixed_point_subtractor.sv | 119 +++++++++++
 tb/tb_signed_pipelined_fixed_point_subtractor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/signed_pipelined_fixed_point_subtractor.sv
// Two-stage split-borrow subtractor: Diff = Sum - B, with valid/ready backpressure.
// Optional clamp of the result to the W-bit range when SUB_SATURATE_EN is defined.
module signed_pipelined_fixed_point_subtractor #(
  parameter int W         = 8,
  parameter int FRAC_BITS = 4,
  parameter int LO        = (W + 2) / 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W:0]     Sum,
  input  logic [W-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W+1:0]   Diff,
  output logic           ovf
);

  localparam int DW = W + 2;
  localparam int HI = DW - LO;

  // Parameter sanity at elaboration; FRAC_BITS only describes the Q-format.
  if (FRAC_BITS < 0 || FRAC_BITS > W) begin : g_bad_frac
    $error("FRAC_BITS must lie in [0, W]");
  end
  if (LO < 1 || LO >= DW) begin : g_bad_lo
    $error("LO must lie in [1, W+1]");
  end

  typedef struct packed {
    logic [LO-1:0] lo;
    logic          c;
    logic [HI-1:0] s_hi;
    logic [HI-1:0] nb_hi;
  } s1_t;

  logic [2:1]    vld_pipe;
  logic          adv1, adv2;
  logic [DW-1:0] sum_x, nb_x;
  logic [LO:0]   lo_sum;
  s1_t           s1_d, s1_q;
  logic [HI-1:0] hi;
  logic [DW-1:0] full;
  logic [DW-1:0] diff_d, diff_q;

  assign adv2      = !vld_pipe[2] | out_ready;
  assign adv1      = !vld_pipe[1] | adv2;
  assign in_ready  = adv1;
  assign out_valid = vld_pipe[2];
  assign Diff      = diff_q;

  // Stage 1: low slice of Sum + ~B + 1; carry out replaces the borrow.
  assign sum_x  = {Sum[W], Sum};
  assign nb_x   = ~{{2{B[W-1]}}, B};
  assign lo_sum = {1'b0, sum_x[LO-1:0]} + {1'b0, nb_x[LO-1:0]} + (LO+1)'(1);

  always_comb begin
    s1_d       = '0;
    s1_d.lo    = lo_sum[LO-1:0];
    s1_d.c     = lo_sum[LO];
    s1_d.s_hi  = sum_x[DW-1:LO];
    s1_d.nb_hi = nb_x[DW-1:LO];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      s1_q        <= '0;
    end else if (adv1) begin
      vld_pipe[1] <= in_valid;
      s1_q        <= s1_d;
    end
  end

  // Stage 2: upper slice absorbs the carry.
  assign hi   = s1_q.s_hi + s1_q.nb_hi + HI'(s1_q.c);
  assign full = {hi, s1_q.lo};

`ifdef SUB_SATURATE_EN
  logic fits, ovf_d, ovf_q;

  // Result fits W bits when the top three bits are all copies of the sign.
  assign fits = (&full[DW-1:W-1]) | ~(|full[DW-1:W-1]);

  always_comb begin
    diff_d = full;
    ovf_d  = 1'b0;
    if (!fits) begin
      ovf_d = 1'b1;
      if (full[DW-1])
        diff_d = {{3{1'b1}}, {(W-1){1'b0}}};
      else
        diff_d = {{3{1'b0}}, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (adv2) ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign diff_d = full;
  assign ovf    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[2] <= 1'b0;
      diff_q      <= '0;
    end else if (adv2) begin
      vld_pipe[2] <= vld_pipe[1];
      diff_q      <= diff_d;
    end
  end

endmodule

// File: tb/tb_signed_pipelined_fixed_point_subtractor.sv
// Scoreboard bench: driver pushes reference results, monitor pops on each output transfer.
module tb_signed_pipelined_fixed_point_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [8:0] Sum = '0;
  logic [7:0] B = '0;
  logic       in_ready, out_valid, ovf;
  logic [9:0] Diff;

  signed_pipelined_fixed_point_subtractor dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Sum(Sum), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Diff(Diff), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int diff;
    bit ovf;
    int cyc;
    bit lat;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         occ = 0;
  bit         lat_mode = 1'b1;
  bit         held_v = 1'b0;
  logic [9:0] held_d;
  logic       held_o;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: plain integer subtraction, optionally clamped to 8-bit range.
  function automatic exp_t model(int s, int b);
    exp_t e;
    e.diff = s - b;
    e.ovf  = 1'b0;
`ifdef SUB_SATURATE_EN
    if (e.diff > 127)       begin e.diff = 127;  e.ovf = 1'b1; end
    else if (e.diff < -128) begin e.diff = -128; e.ovf = 1'b1; end
`endif
    e.cyc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Call at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(int s, int b);
    exp_t e;
    in_valid = 1'b1;
    Sum = 9'(s);
    B   = 8'(b);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e = model(s, b);
        e.cyc = cyc;
        e.lat = lat_mode;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", int'(in_ready), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    chk("drain_empty", q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        held_v = 1'b0;
        continue;
      end
      chk("in_ready", int'(in_ready), int'(!(occ == 2 && !out_ready)));
      if (held_v) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_diff", int'(Diff), int'(held_d));
        chk("stall_ovf", int'(ovf), int'(held_o));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_output", int'(out_valid), 0);
        else begin
          e = q.pop_front();
          chk("diff", int'($signed(Diff)), e.diff);
          chk("ovf", int'(ovf), int'(e.ovf));
          if (e.lat) chk("latency", cyc - e.cyc, 2);
        end
      end
      occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      held_v = out_valid && !out_ready;
      held_d = Diff;
      held_o = ovf;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end

  int ds[7] = '{25, -15, 126, 32, -128, -256, 254};
  int db[7] = '{10,  -5,  -1,  1,    1,  127, -128};

  initial begin
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_diff", int'(Diff), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: basic, borrow across split, extreme range
    lat_mode = 1'b1;
    for (int i = 0; i < 7; i++) send(ds[i], db[i]);
    drain();

    // Backpressure: 5 back-to-back with out_ready low for four cycles
    lat_mode = 1'b0;
    fork
      for (int i = 0; i < 5; i++)
        send(int'($urandom_range(0, 510)) - 256, int'($urandom_range(0, 255)) - 128);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Full throughput
    lat_mode = 1'b1;
    for (int i = 0; i < 16; i++)
      send(int'($urandom_range(0, 510)) - 256, int'($urandom_range(0, 255)) - 128);
    drain();

    // Reset with two entries in flight
    lat_mode = 1'b0;
    out_ready = 1'b0;
    send(100, 3);
    send(-50, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_diff", int'(Diff), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    q.delete();
    occ = 0;
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    lat_mode = 1'b1;
    send(7, -9);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
